// File: rtl/tdc_tx_packer.sv
// tdc_tx_packer
//   Packs TDC hit records into 3-byte packets and hands them one byte at a
//   time to the UART transmitter, paced by the transmitter's idle/busy flag.
//   Hits are buffered in a DEPTH-entry FIFO; hits arriving while it is full
//   are dropped and counted.
//
//   Packet: byte0 = {SYNC, chan[4:0]}, byte1 = time[15:8], byte2 = time[7:0]
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   enable        streaming enable; a packet in flight always completes
//   hit_valid     one-cycle strobe qualifying hit_chan / hit_time
//   hit_chan      channel number 0..31
//   hit_time      16-bit time stamp
//   uart_ready    transmitter idle (1) / busy (0)
//   tx_byte       byte for transmitter data_in, held outside the load strobe
//   tx_rdy        one-cycle load strobe to the transmitter
//   overflow      sticky dropped-hit flag
//   clr_ovf       clears overflow and drop_cnt
//   drop_cnt      dropped-hit count, saturating at 255
//   fifo_cnt      FIFO occupancy 0..DEPTH
module tdc_tx_packer #(
    parameter int unsigned DEPTH = 16,
    parameter logic [2:0]  SYNC  = 3'b101
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      hit_valid,
    input  logic [4:0]                hit_chan,
    input  logic [15:0]               hit_time,
    input  logic                      uart_ready,
    output logic [7:0]                tx_byte,
    output logic                      tx_rdy,
    output logic                      overflow,
    input  logic                      clr_ovf,
    output logic [7:0]                drop_cnt,
    output logic [$clog2(DEPTH):0]    fifo_cnt
);

    localparam int unsigned    AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_LO,
        WAIT_HI
    } state_t;

    state_t        state, state_nx;
    logic [20:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [23:0]   pkt;
    logic [23:0]   head_pkt;
    logic [1:0]    idx, idx_nx;
    logic [7:0]    byte_nx;
    logic          popped;
    logic          pop, push, drop;

    assign head_pkt = {SYNC, mem[rd_ptr]};
    assign push     = hit_valid && ((fifo_cnt < FULL_CNT) || pop);
    assign drop     = hit_valid && !push;

    // The pop happens on the first edge spent in LOAD only; popped keeps a
    // LOAD that is stalled on uart_ready from popping again. When LOAD exits
    // on that same first edge, byte0 comes straight from the FIFO head since
    // pkt is only being written on that edge.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        idx_nx   = idx;
        byte_nx  = tx_byte;
        case (state)
            IDLE: begin
                if (enable && (fifo_cnt != '0))
                    state_nx = LOAD;
            end
            LOAD: begin
                pop = !popped;
                if (uart_ready) begin
                    state_nx = SEND;
                    idx_nx   = 2'd0;
                    byte_nx  = popped ? pkt[23:16] : head_pkt[23:16];
                end
            end
            SEND: begin
                state_nx = WAIT_LO;
            end
            WAIT_LO: begin
                if (!uart_ready)
                    state_nx = WAIT_HI;
            end
            WAIT_HI: begin
                if (uart_ready) begin
                    if (idx < 2'd2) begin
                        state_nx = SEND;
                        idx_nx   = idx + 2'd1;
                        byte_nx  = (idx == 2'd0) ? pkt[15:8] : pkt[7:0];
                    end else if (enable && (fifo_cnt != '0)) begin
                        state_nx = LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            popped  <= 1'b0;
            pkt     <= '0;
            tx_byte <= '0;
            tx_rdy  <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            popped  <= (state == LOAD) && (state_nx == LOAD);
            if (pop)
                pkt <= head_pkt;
            // Strobe and byte are registered on the edge that enters SEND.
            tx_rdy  <= (state_nx == SEND);
            if (state_nx == SEND)
                tx_byte <= byte_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {hit_chan, hit_time};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // A drop in the same cycle as clr_ovf is counted after the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            overflow <= drop;
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_tdc_tx_packer.sv
// Directed bench for tdc_tx_packer. A transmitter model answers each tx_rdy
// by going busy for 10 cycles and records every strobed byte.
module tb_tdc_tx_packer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        hit_valid;
    logic [4:0]  hit_chan;
    logic [15:0] hit_time;
    logic        uart_ready;
    logic [7:0]  tx_byte;
    logic        tx_rdy;
    logic        overflow;
    logic        clr_ovf;
    logic [7:0]  drop_cnt;
    logic [4:0]  fifo_cnt;

    int          total;
    int          passes;
    int          strobes;
    int          violations;
    int          busy;
    logic        prev_rdy;
    logic [7:0]  got[$];

    tdc_tx_packer #(.DEPTH(16), .SYNC(3'b101)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .hit_valid  (hit_valid),
        .hit_chan   (hit_chan),
        .hit_time   (hit_time),
        .uart_ready (uart_ready),
        .tx_byte    (tx_byte),
        .tx_rdy     (tx_rdy),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .drop_cnt   (drop_cnt),
        .fifo_cnt   (fifo_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter: busy for 10 cycles after each load strobe.
    initial begin
        uart_ready = 1'b1;
        busy       = 0;
        prev_rdy   = 1'b0;
        violations = 0;
        strobes    = 0;
        forever begin
            @(negedge clk);
            if (tx_rdy === 1'b1) begin
                if (prev_rdy || !uart_ready)
                    violations++;
                got.push_back(tx_byte);
                strobes++;
                busy       = 10;
                uart_ready = 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0)
                    uart_ready = 1'b1;
            end
            prev_rdy = (tx_rdy === 1'b1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k;
        k = 0;
        while (strobes < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("strobe_wait", 32'(strobes >= n), 32'd1);
    endtask

    task automatic drive_hit(input logic [4:0] c, input logic [15:0] t);
        @(negedge clk);
        hit_chan  = c;
        hit_time  = t;
        hit_valid = 1'b1;
    endtask

    task automatic idle_hit();
        @(negedge clk);
        hit_valid = 1'b0;
    endtask

    task automatic clear_log();
        got.delete();
        strobes = 0;
    endtask

    initial begin
        total     = 0;
        passes    = 0;
        rst       = 1'b1;
        enable    = 1'b1;
        hit_valid = 1'b0;
        hit_chan  = '0;
        hit_time  = '0;
        clr_ovf   = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_tx_rdy", tx_rdy, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 8'h00);
        chk("rst_fifo_cnt", fifo_cnt, 5'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single hit, latency and byte order
        clear_log();
        @(negedge clk);
        hit_chan = 5'd5; hit_time = 16'h1234; hit_valid = 1'b1;
        @(posedge clk); #1;                       // E0
        chk("lat_e0_cnt", fifo_cnt, 5'd1);
        chk("lat_e0_rdy", tx_rdy, 1'b0);
        @(negedge clk);
        hit_valid = 1'b0;
        @(posedge clk); #1;                       // E1
        chk("lat_e1_rdy", tx_rdy, 1'b0);
        chk("lat_e1_cnt", fifo_cnt, 5'd1);
        @(posedge clk); #1;                       // E2
        chk("lat_e2_rdy", tx_rdy, 1'b1);
        chk("lat_e2_byte", tx_byte, 8'hA5);
        chk("lat_e2_cnt", fifo_cnt, 5'd0);
        wait_strobes(3, 200);
        repeat (30) @(posedge clk);
        #1;
        chk("single_strobes", strobes, 3);
        if (got.size() == 3) begin
            chk("single_b0", got[0], 8'hA5);
            chk("single_b1", got[1], 8'h12);
            chk("single_b2", got[2], 8'h34);
        end else begin
            chk("single_nbytes", got.size(), 3);
        end
        chk("single_hold", tx_byte, 8'h34);

        // 17 hits with streaming disabled, then drain in order
        @(negedge clk);
        enable = 1'b0;
        clear_log();
        for (int i = 0; i < 17; i++)
            drive_hit(5'(i), 16'hB000 + 16'(i));
        idle_hit();
        chk("burst_cnt", fifo_cnt, 5'd16);
        chk("burst_ovf", overflow, 1'b1);
        chk("burst_drop", drop_cnt, 8'd1);
        chk("burst_no_tx", strobes, 0);
        enable = 1'b1;
        wait_strobes(48, 2000);
        repeat (30) @(posedge clk);
        #1;
        chk("burst_strobes", strobes, 48);
        chk("burst_empty", fifo_cnt, 5'd0);
        if (got.size() == 48) begin
            for (int k = 0; k < 16; k++) begin
                chk("burst_b0", got[3*k],   8'hA0 | 8'(k));
                chk("burst_b1", got[3*k+1], 8'hB0);
                chk("burst_b2", got[3*k+2], 8'(k));
            end
        end else begin
            chk("burst_nbytes", got.size(), 48);
        end

        // Saturation of drop_cnt, then clear
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 300; i++)
            drive_hit(5'(i), 16'(i));
        idle_hit();
        chk("sat_drop", drop_cnt, 8'd255);
        chk("sat_ovf", overflow, 1'b1);
        chk("sat_cnt", fifo_cnt, 5'd16);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_drop", drop_cnt, 8'd0);

        // Drop coincident with clr_ovf: clear first, then count
        @(negedge clk);
        hit_chan = 5'd1; hit_time = 16'h0001; hit_valid = 1'b1; clr_ovf = 1'b1;
        @(negedge clk);
        hit_valid = 1'b0; clr_ovf = 1'b0;
        chk("coinc_ovf", overflow, 1'b1);
        chk("coinc_drop", drop_cnt, 8'd1);

        // Empty everything, queue two hits, drop enable after byte0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_cnt", fifo_cnt, 5'd0);
        chk("rst2_ovf", overflow, 1'b0);
        repeat (12) @(negedge clk);               // let the model go idle
        drive_hit(5'd7, 16'hBEEF);
        drive_hit(5'd9, 16'h0102);
        idle_hit();
        clear_log();
        enable = 1'b1;
        wait_strobes(1, 50);
        @(negedge clk);
        enable = 1'b0;
        wait_strobes(3, 200);
        repeat (40) @(posedge clk);
        #1;
        chk("en_strobes", strobes, 3);
        chk("en_cnt", fifo_cnt, 5'd1);
        if (got.size() == 3) begin
            chk("en_b0", got[0], 8'hA7);
            chk("en_b1", got[1], 8'hBE);
            chk("en_b2", got[2], 8'hEF);
        end else begin
            chk("en_nbytes", got.size(), 3);
        end

        // Reset while in WAIT_LO after byte1
        drive_hit(5'd3, 16'h5566);
        idle_hit();
        clear_log();
        enable = 1'b1;
        wait_strobes(2, 200);                     // returns #1 after SEND->WAIT_LO edge
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_rdy", tx_rdy, 1'b0);
        chk("mid_rst_byte", tx_byte, 8'h00);
        chk("mid_rst_cnt", fifo_cnt, 5'd0);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_drop", drop_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("mid_rst_strobes", strobes, 2);
        if (got.size() >= 2) begin
            chk("mid_b0", got[0], 8'hA9);
            chk("mid_b1", got[1], 8'h01);
        end else begin
            chk("mid_nbytes", got.size(), 2);
        end

        chk("protocol_violations", violations, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
